download_packer: RTL and testbench

DOWNLOAD_PACKER -- requirements
Module: download_packer

---
 rtl/download_packer.sv | 178 +++++++++++++++++
 tb/tb_download_packer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/download_packer.sv
// Packs 16-bit ROM download words into 64-bit DDR line writes. A one-entry skid
// register absorbs the first word of the next line while the current line drains.
module download_packer #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        download_cs,
  input  logic        download_wr,
  input  logic [24:0] download_addr,
  input  logic [15:0] download_dout,
  output logic        download_waitReq,
  output logic        ddr_wr,
  output logic [31:0] ddr_addr,
  output logic [63:0] ddr_din,
  output logic [7:0]  ddr_mask,
  output logic [7:0]  ddr_burstLength,
  input  logic        ddr_waitReq,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [63:0] line_din, din_nxt;
  logic [7:0]  line_mask, mask_nxt;
  logic [31:0] line_addr, addr_nxt;
  logic        skid_valid, skid_valid_nxt;
  logic [23:0] skid_addr, skid_addr_nxt;
  logic [15:0] skid_data, skid_data_nxt;
  logic        cs_q;
  logic        fin_pend, fin_nxt;
  logic        done_q, done_nxt;

  logic        cs_fall, wr_ok, finish, accept;
  logic [1:0]  in_k, skid_k;
  logic [31:0] in_line, skid_line;
  logic        unused_addr_lsb;

  function automatic logic [31:0] line_of(input logic [21:0] idx);
    return BASE_ADDR + {7'd0, idx, 3'b000};
  endfunction

  function automatic logic [63:0] place(input logic [63:0] d, input logic [1:0] k,
                                        input logic [15:0] w);
    d[{k, 4'b0000} +: 16] = w;
    return d;
  endfunction

  function automatic logic [7:0] enable(input logic [7:0] m, input logic [1:0] k);
    m[{k, 1'b0} +: 2] = 2'b11;
    return m;
  endfunction

  // Always-even word addresses leave bit 0 carrying no information.
  assign unused_addr_lsb = download_addr[0];

  // A write in the very cycle cs drops still belongs to the download.
  assign cs_fall   = cs_q & ~download_cs;
  assign wr_ok     = download_wr & (download_cs | cs_fall);
  assign finish    = cs_fall | fin_pend;
  assign accept    = ddr_wr & ~ddr_waitReq;
  assign in_k      = download_addr[2:1];
  assign in_line   = line_of(download_addr[24:3]);
  assign skid_k    = skid_addr[1:0];
  assign skid_line = line_of(skid_addr[23:2]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  // NOTE: the line buffer and skid register are plain flops, so they are reset
  // explicitly; nothing stale may reach the DDR after reset is released.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      line_din   <= '0;
      line_mask  <= '0;
      line_addr  <= '0;
      skid_valid <= 1'b0;
      skid_addr  <= '0;
      skid_data  <= '0;
      cs_q       <= 1'b0;
      fin_pend   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      line_din   <= din_nxt;
      line_mask  <= mask_nxt;
      line_addr  <= addr_nxt;
      skid_valid <= skid_valid_nxt;
      skid_addr  <= skid_addr_nxt;
      skid_data  <= skid_data_nxt;
      cs_q       <= download_cs;
      fin_pend   <= fin_nxt;
      done_q     <= done_nxt;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    din_nxt        = line_din;
    mask_nxt       = line_mask;
    addr_nxt       = line_addr;
    skid_valid_nxt = skid_valid;
    skid_addr_nxt  = skid_addr;
    skid_data_nxt  = skid_data;
    done_nxt       = 1'b0;

    unique case (state)
      IDLE: begin
        if (wr_ok) begin
          din_nxt   = place(64'd0, in_k, download_dout);
          mask_nxt  = enable(8'd0, in_k);
          addr_nxt  = in_line;
          state_nxt = finish ? FLUSH : ((in_k == 2'd3) ? WRITE : FILL);
        end else if (finish) begin
          done_nxt = 1'b1;
        end
      end
      FILL: begin
        if (wr_ok && (in_line == line_addr)) begin
          din_nxt   = place(line_din, in_k, download_dout);
          mask_nxt  = enable(line_mask, in_k);
          state_nxt = finish ? FLUSH : ((in_k == 2'd3) ? WRITE : FILL);
        end else if (wr_ok) begin
          skid_valid_nxt = 1'b1;
          skid_addr_nxt  = download_addr[24:1];
          skid_data_nxt  = download_dout;
          state_nxt      = WRITE;
        end else if (finish) begin
          state_nxt = FLUSH;
        end
      end
      WRITE: begin
        if (accept) begin
          din_nxt  = '0;
          mask_nxt = '0;
          if (skid_valid) begin
            din_nxt        = place(64'd0, skid_k, skid_data);
            mask_nxt       = enable(8'd0, skid_k);
            addr_nxt       = skid_line;
            skid_valid_nxt = 1'b0;
            state_nxt      = finish ? FLUSH : ((skid_k == 2'd3) ? WRITE : FILL);
          end else begin
            state_nxt = IDLE;
            done_nxt  = finish;
          end
        end
      end
      FLUSH: begin
        if (accept) begin
          din_nxt   = '0;
          mask_nxt  = '0;
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A cs fall is remembered until its done pulse is issued.
    if (done_nxt)     fin_nxt = 1'b0;
    else if (cs_fall) fin_nxt = 1'b1;
    else              fin_nxt = fin_pend;
  end

  always_comb begin
    ddr_wr           = (state == WRITE) || (state == FLUSH);
    download_waitReq = ddr_wr || skid_valid;
    ddr_addr         = line_addr;
    ddr_din          = line_din;
    ddr_mask         = line_mask;
    ddr_burstLength  = 8'd1;
    done             = done_q;
  end

endmodule

// File: tb/tb_download_packer.sv
// Directed bench for download_packer: line packing, partial flush, DDR stall,
// skid hand-over, mid-write reset and a small sequential image download.
module tb_download_packer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        download_cs = 1'b0;
  logic        download_wr = 1'b0;
  logic [24:0] download_addr = '0;
  logic [15:0] download_dout = '0;
  logic        download_waitReq;
  logic        ddr_wr;
  logic [31:0] ddr_addr;
  logic [63:0] ddr_din;
  logic [7:0]  ddr_mask;
  logic [7:0]  ddr_burstLength;
  logic        ddr_waitReq = 1'b0;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  download_packer dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .download_cs     (download_cs),
    .download_wr     (download_wr),
    .download_addr   (download_addr),
    .download_dout   (download_dout),
    .download_waitReq(download_waitReq),
    .ddr_wr          (ddr_wr),
    .ddr_addr        (ddr_addr),
    .ddr_din         (ddr_din),
    .ddr_mask        (ddr_mask),
    .ddr_burstLength (ddr_burstLength),
    .ddr_waitReq     (ddr_waitReq),
    .done            (done)
  );

  logic [31:0] acc_addr[$];
  logic [63:0] acc_din[$];
  logic [7:0]  acc_mask[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cycle = 0;
  int          acc_cycle = 0;
  bit          rand_wait = 1'b0;
  bit          mem_en = 1'b0;
  logic [7:0]  mem [0:4095];
  logic [15:0] img [0:2047];

  // DDR side observer: logs accepted writes and applies them to a byte memory.
  always @(negedge clock) begin
    int off;
    cyc++;
    if (done) begin
      done_cnt++;
      done_cycle = cyc;
    end
    if (ddr_wr && !ddr_waitReq) begin
      acc_addr.push_back(ddr_addr);
      acc_din.push_back(ddr_din);
      acc_mask.push_back(ddr_mask);
      acc_cycle = cyc;
      off = int'(ddr_addr - 32'h3000_0000);
      if (mem_en && off >= 0 && off < 4096)
        for (int b = 0; b < 8; b++)
          if (ddr_mask[b]) mem[off + b] = ddr_din[8*b +: 8];
    end
  end

  always @(posedge clock) begin
    #1;
    if (rand_wait) ddr_waitReq = ($urandom_range(0, 1) == 1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_word(input logic [24:0] a, input logic [15:0] d);
    int n = 0;
    while (download_waitReq && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("waitreq_timeout", 64'(download_waitReq), 64'd0);
    download_wr   = 1'b1;
    download_addr = a;
    download_dout = d;
    @(negedge clock);
    download_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_log();
    acc_addr.delete();
    acc_din.delete();
    acc_mask.delete();
    done_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_ddr_wr"},   64'(ddr_wr),           64'd0);
    check({p, "_mask"},     64'(ddr_mask),         64'd0);
    check({p, "_din"},      ddr_din,               64'd0);
    check({p, "_addr"},     64'(ddr_addr),         64'd0);
    check({p, "_waitreq"},  64'(download_waitReq), 64'd0);
    check({p, "_done"},     64'(done),             64'd0);
    check({p, "_burst"},    64'(ddr_burstLength),  64'd1);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int good;
    int bad;
    int n;

    // Reset state
    #12;
    check_reset_outputs("rst");
    @(negedge clock);
    reset_n = 1'b1;
    idle(2);

    // Full sequential line
    clear_log();
    download_cs = 1'b1;
    drive_word(25'h00, 16'h1111);
    drive_word(25'h02, 16'h2222);
    drive_word(25'h04, 16'h3333);
    drive_word(25'h06, 16'h4444);
    idle(3);
    check("v1_count", 64'(acc_addr.size()), 64'd1);
    check("v1_addr",  64'(acc_addr[0]), 64'h3000_0000);
    check("v1_din",   acc_din[0], 64'h4444_3333_2222_1111);
    check("v1_mask",  64'(acc_mask[0]), 64'hFF);
    download_cs = 1'b0;
    idle(3);
    check("v1_done_idle_fall", 64'(done_cnt), 64'd1);

    // Partial line flush on cs fall
    clear_log();
    download_cs = 1'b1;
    drive_word(25'h0A, 16'hABCD);
    download_cs = 1'b0;
    idle(5);
    check("v2_count", 64'(acc_addr.size()), 64'd1);
    check("v2_addr",  64'(acc_addr[0]), 64'h3000_0008);
    check("v2_din",   acc_din[0], 64'h0000_0000_ABCD_0000);
    check("v2_mask",  64'(acc_mask[0]), 64'h0C);
    check("v2_done_cnt", 64'(done_cnt), 64'd1);
    check("v2_done_lag", 64'(done_cycle - acc_cycle), 64'd1);

    // DDR stall for 10 cycles
    clear_log();
    ddr_waitReq = 1'b1;
    download_cs = 1'b1;
    drive_word(25'h20, 16'h5555);
    drive_word(25'h22, 16'h6666);
    drive_word(25'h24, 16'h7777);
    drive_word(25'h26, 16'h8888);
    good = 0;
    for (int i = 0; i < 10; i++) begin
      if (ddr_wr && download_waitReq && ddr_din == 64'h8888_7777_6666_5555 &&
          ddr_addr == 32'h3000_0020 && ddr_mask == 8'hFF) good++;
      @(posedge clock);
      #1;
    end
    check("v3_held_cycles", 64'(good), 64'd10);
    check("v3_no_early_accept", 64'(acc_addr.size()), 64'd0);
    ddr_waitReq = 1'b0;
    idle(3);
    check("v3_count", 64'(acc_addr.size()), 64'd1);
    check("v3_din",   acc_din[0], 64'h8888_7777_6666_5555);
    check("v3_waitreq_after", 64'(download_waitReq), 64'd0);
    download_cs = 1'b0;
    idle(3);

    // Line change through the skid register
    clear_log();
    download_cs = 1'b1;
    drive_word(25'h00, 16'hAAAA);
    drive_word(25'h10, 16'hBBBB);
    check("v4_waitreq_between", 64'(download_waitReq), 64'd1);
    idle(3);
    download_cs = 1'b0;
    idle(5);
    check("v4_count", 64'(acc_addr.size()), 64'd2);
    check("v4_addr0", 64'(acc_addr[0]), 64'h3000_0000);
    check("v4_din0",  acc_din[0], 64'h0000_0000_0000_AAAA);
    check("v4_mask0", 64'(acc_mask[0]), 64'h03);
    check("v4_addr1", 64'(acc_addr[1]), 64'h3000_0010);
    check("v4_din1",  acc_din[1], 64'h0000_0000_0000_BBBB);
    check("v4_mask1", 64'(acc_mask[1]), 64'h03);
    check("v4_done",  64'(done_cnt), 64'd1);

    // Overwrite, write on the cs-fall cycle, write with cs low
    clear_log();
    download_cs = 1'b1;
    drive_word(25'h40, 16'h1234);
    drive_word(25'h40, 16'h5678);
    download_cs   = 1'b0;
    download_wr   = 1'b1;
    download_addr = 25'h42;
    download_dout = 16'h9ABC;
    @(negedge clock);
    download_wr = 1'b0;
    idle(5);
    download_wr   = 1'b1;
    download_addr = 25'h44;
    download_dout = 16'hFFFF;
    @(negedge clock);
    download_wr = 1'b0;
    idle(5);
    check("mx_count", 64'(acc_addr.size()), 64'd1);
    check("mx_addr",  64'(acc_addr[0]), 64'h3000_0040);
    check("mx_din",   acc_din[0], 64'h0000_0000_9ABC_5678);
    check("mx_mask",  64'(acc_mask[0]), 64'h0F);
    check("mx_done",  64'(done_cnt), 64'd1);

    // Reset in the middle of a stalled write
    clear_log();
    ddr_waitReq = 1'b1;
    download_cs = 1'b1;
    drive_word(25'h80, 16'hC0C0);
    drive_word(25'h82, 16'hC1C1);
    drive_word(25'h84, 16'hC2C2);
    drive_word(25'h86, 16'hC3C3);
    check("v5_pre_ddr_wr", 64'(ddr_wr), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("v5");
    download_cs = 1'b0;
    ddr_waitReq = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    idle(10);
    check("v5_no_wr", 64'(acc_addr.size()), 64'd0);
    check("v5_no_done", 64'(done_cnt), 64'd0);

    // Sequential image download with random DDR stalls
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    for (int i = 0; i < 2048; i++) img[i] = 16'($urandom);
    clear_log();
    mem_en      = 1'b1;
    rand_wait   = 1'b1;
    download_cs = 1'b1;
    for (int i = 0; i < 2048; i++) drive_word(25'(2 * i), img[i]);
    download_cs = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    idle(5);
    rand_wait = 1'b0;
    @(posedge clock);
    #2 ddr_waitReq = 1'b0;
    idle(3);
    bad = 0;
    for (int i = 0; i < 2048; i++)
      if ({mem[2*i+1], mem[2*i]} !== img[i]) bad++;
    check("v6_bad_words", 64'(bad), 64'd0);
    check("v6_writes", 64'(acc_addr.size()), 64'd512);
    check("v6_done_once", 64'(done_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
